shift_deser_rx: RTL and testbench

//  Serial-to-parallel receiver: the far end of a shift-register serial link. Collects W bits

---
 rtl/shift_deser_rx.sv | 134 +++++++++++++
 tb/tb_shift_deser_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver: assembles framed W-bit words from a 1-bit stream into a valid/ready output register.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit per frame and the parity_err output).
module shift_deser_rx #(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin_valid,
  input  logic         sin,
  input  logic         sin_start,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         busy,
  output logic         overrun,
  output logic         resync
`ifdef PARITY_CHECK_EN
  ,
  output logic         parity_err
`endif
);

  localparam int CW = $clog2(W + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_sr, w_sr_nxt, w_shifted, w_word;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_done, w_resync, w_perr, w_load;

  assign w_shifted = LSB_FIRST ? {sin, r_sr[W-1:1]} : {r_sr[W-2:0], sin};

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_resync    = 1'b0;
    w_perr      = 1'b0;
    w_word      = w_shifted;
    unique case (r_state)
      S_IDLE: begin
        if (sin_valid && sin_start) begin
          w_state_nxt = S_SHIFT;
          w_sr_nxt    = w_shifted;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_SHIFT: begin
        if (sin_valid) begin
          w_sr_nxt = w_shifted;
          if (sin_start) begin
            w_resync  = 1'b1;
            w_cnt_nxt = CW'(1);
          end else if (r_cnt == CW'(W - 1)) begin
`ifdef PARITY_CHECK_EN
            w_state_nxt = S_PARITY;
            w_cnt_nxt   = CW'(W);
`else
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        if (sin_valid) begin
          if (sin_start) begin
            w_resync    = 1'b1;
            w_sr_nxt    = w_shifted;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = S_SHIFT;
          end else begin
            // Even parity: odd population over data plus parity bit is an error.
            w_done      = 1'b1;
            w_word      = r_sr;
            w_perr      = ^{r_sr, sin};
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A finished word may enter the output register only if it is empty or being drained this cycle.
  assign w_load = w_done && (!m_valid || m_ready);
  assign busy   = (r_state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      overrun    <= 1'b0;
      resync     <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      overrun <= w_done && !w_load;
      resync  <= w_resync;
      if (w_load) begin
        m_data     <= w_word;
        m_valid    <= 1'b1;
`ifdef PARITY_CHECK_EN
        parity_err <= w_perr;
`endif
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_deser_rx.sv
// Bench for shift_deser_rx: MSB-first and LSB-first instances share one stream, checked each cycle against a frame-level model.
// Honours PARITY_CHECK_EN when defined.
module tb_shift_deser_rx;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin_valid = 1'b0, sin = 1'b0, sin_start = 1'b0, m_ready = 1'b0;
  logic [W-1:0] m_data_m, m_data_l;
  logic         m_valid_m, m_valid_l, busy_m, busy_l, ovr_m, ovr_l, rsy_m, rsy_l;
`ifdef PARITY_CHECK_EN
  logic         perr_m, perr_l;
`endif

  always #5 clk = ~clk;

  shift_deser_rx #(.W(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin(sin), .sin_start(sin_start),
    .m_data(m_data_m), .m_valid(m_valid_m), .m_ready(m_ready),
    .busy(busy_m), .overrun(ovr_m), .resync(rsy_m)
`ifdef PARITY_CHECK_EN
    , .parity_err(perr_m)
`endif
  );

  shift_deser_rx #(.W(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin(sin), .sin_start(sin_start),
    .m_data(m_data_l), .m_valid(m_valid_l), .m_ready(m_ready),
    .busy(busy_l), .overrun(ovr_l), .resync(rsy_l)
`ifdef PARITY_CHECK_EN
    , .parity_err(perr_l)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ovr_cnt  = 0;

  // Reference model: bits collected since the last start, plus the expected output register.
  bit           frame_q[$];
  bit           in_frame;
  logic         exp_valid, exp_ovr, exp_rsy, exp_perr;
  logic [W-1:0] exp_msb, exp_lsb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    frame_q.delete();
    in_frame  = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_rsy   = 1'b0;
    exp_perr  = 1'b0;
    exp_msb   = '0;
    exp_lsb   = '0;
  endtask

  task automatic model_update(input logic v, input logic b, input logic s, input logic r);
    bit done = 1'b0;
    int wm = 0, wl = 0, ones = 0;
    exp_rsy = 1'b0;
    exp_ovr = 1'b0;
    if (v) begin
      if (s) begin
        if (in_frame) exp_rsy = 1'b1;
        frame_q.delete();
        frame_q.push_back(b);
        in_frame = 1'b1;
      end else if (in_frame) begin
        frame_q.push_back(b);
        if (frame_q.size() == FRAME_LEN) begin
          done     = 1'b1;
          in_frame = 1'b0;
        end
      end
    end
    if (done) begin
      for (int i = 0; i < W; i++) begin
        wm = wm * 2 + int'(frame_q[i]);
        wl = wl + (int'(frame_q[i]) << i);
      end
      for (int i = 0; i < FRAME_LEN; i++) ones += int'(frame_q[i]);
      if (!exp_valid || r) begin
        exp_valid = 1'b1;
        exp_msb   = W'(wm);
        exp_lsb   = W'(wl);
        exp_perr  = (ones % 2) != 0;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && r) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("m_valid_msb", 32'(m_valid_m), 32'(exp_valid));
    check("m_valid_lsb", 32'(m_valid_l), 32'(exp_valid));
    check("m_data_msb",  32'(m_data_m),  32'(exp_msb));
    check("m_data_lsb",  32'(m_data_l),  32'(exp_lsb));
    check("busy",        32'({busy_m, busy_l}), 32'({in_frame, in_frame}));
    check("overrun",     32'({ovr_m, ovr_l}),   32'({exp_ovr, exp_ovr}));
    check("resync",      32'({rsy_m, rsy_l}),   32'({exp_rsy, exp_rsy}));
`ifdef PARITY_CHECK_EN
    if (exp_valid) check("parity_err", 32'({perr_m, perr_l}), 32'({exp_perr, exp_perr}));
`endif
    if (ovr_m) ovr_cnt++;
  endtask

  // Called at a falling edge: drive, advance the model, clock, then check at the next falling edge.
  task automatic step(input logic v, input logic b, input logic s, input logic r);
    sin_valid = v;
    sin       = b;
    sin_start = s;
    m_ready   = r;
    model_update(v, b, s, r);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_bits(input logic [W-1:0] word, input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, word[W-1-i], i == 0, r);
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic r, input logic flip_parity);
    send_bits(word, W, r);
`ifdef PARITY_CHECK_EN
    step(1'b1, (^word) ^ flip_parity, 1'b0, r);
`else
    if (flip_parity) step(1'b0, 1'b0, 1'b0, r);
`endif
  endtask

  task automatic do_reset();
    sin_valid = 1'b0;
    sin_start = 1'b0;
    rst       = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check("reset_m_data",  32'(m_data_m), 32'h0);
    check("reset_m_valid", 32'({m_valid_m, m_valid_l}), 32'h0);
    check("reset_flags",   32'({busy_m, ovr_m, rsy_m}), 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1);   // stray bit outside a frame is ignored

    // Directed: MSB-first A5, then consumed after one cycle.
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t1_data",  32'(m_data_m), 32'hA5);
    check("t1_valid", 32'(m_valid_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_drop",  32'(m_valid_m), 32'h0);

    // Directed: 1,1,0,0,0,0,0,0 gives 03 LSB-first, C0 MSB-first.
    send_frame(8'hC0, 1'b1, 1'b0);
    check("t2_lsb", 32'(m_data_l), 32'h03);
    check("t2_msb", 32'(m_data_m), 32'hC0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Directed: back-to-back frames with consumer stalled.
    ovr_cnt = 0;
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_data",    32'(m_data_m), 32'h11);
    check("t3_overrun", 32'(ovr_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Directed: restart after 3 bits.
    send_bits(8'hFF, 3, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("t4_data", 32'(m_data_m), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Directed: reset in the middle of a frame.
    send_bits(8'hAA, 5, 1'b0);
    do_reset();
    send_frame(8'hF0, 1'b1, 1'b0);
    check("t5_data", 32'(m_data_m), 32'hF0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
    send_frame(8'h07, 1'b1, 1'b0);
    check("t6_perr_ok", 32'(perr_m), 32'h0);
    send_frame(8'h07, 1'b1, 1'b1);
    check("t6_perr_bad", 32'(perr_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random stream: gaps, noise, restarts and consumer stalls.
    for (int i = 0; i < 1500; i++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 11) == 0);
      step(v, 1'($urandom), s, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
